// File: rtl/layer_pkg.sv
// Shared widths and bit-weight offsets for the Layer3/Layer4 multiplier rows.
// The final 32-bit product is assembled from weighted rows and error vectors.
package layer_pkg;

  localparam int D1_W   = 23;
  localparam int D2_W   = 23;
  localparam int EM_W   = 16;
  localparam int EN_W   = 16;

  localparam int D1_LSB = 1;
  localparam int D2_LSB = 9;
  localparam int EM_LSB = 5;
  localparam int EN_LSB = 13;

  localparam int PROD_W = 32;
  localparam int SUM_W  = PROD_W + 1;

  // Stage-1 contents: A keeps its adder carry as an extra top bit so no
  // overflow information is dropped before stage 2.
  typedef struct packed {
    logic [SUM_W:0]   a;
    logic [SUM_W-1:0] e;
  } stage1_t;

endpackage

// File: rtl/layer4_add33.sv
// Combinational 33-bit adder with carry out, shared by the A and S additions.
module layer4_add33
  import layer_pkg::*;
(
  input  logic [SUM_W-1:0] a,
  input  logic [SUM_W-1:0] b,
  output logic [SUM_W-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/layer4_final_add.sv
// Layer4 final adder: two-stage valid/ready pipeline that sums the weighted
// Layer3 rows into a 32-bit product with an overflow flag, and counts inputs
// carrying a nonzero error vector.
// Optional feature macro: LAYER4_ERROR_RECOVERY_EN (adds E into the result).
module layer4_final_add
  import layer_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [D1_W-1:0]      d1,
  input  logic [D2_W-1:0]      d2,
  input  logic [EM_W-1:0]      em,
  input  logic [EN_W-1:0]      en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PROD_W-1:0]    product,
  output logic                 ovf,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [SUM_W-1:0]  d1_w, d2_w, em_w, en_w;
  logic [SUM_W-1:0]  a_sum, e_sum;
  logic              a_carry;
  stage1_t           s1;
  logic              s1_valid;
  logic              s1_fresh;
  logic              accept;
  logic              s2_load;
  logic [PROD_W-1:0] s_prod;
  logic              s_ovf;

  assign d1_w  = SUM_W'(d1) << D1_LSB;
  assign d2_w  = SUM_W'(d2) << D2_LSB;
  assign em_w  = SUM_W'(em) << EM_LSB;
  assign en_w  = SUM_W'(en) << EN_LSB;
  assign e_sum = em_w + en_w;

  layer4_add33 u_add_a (
    .a     (d1_w),
    .b     (d2_w),
    .sum   (a_sum),
    .carry (a_carry)
  );

  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign s2_load  = s1_valid && (!out_valid || out_ready);

`ifdef LAYER4_ERROR_RECOVERY_EN
  logic [SUM_W-1:0] s_sum;
  logic             s_carry;

  layer4_add33 u_add_s (
    .a     (s1.a[SUM_W-1:0]),
    .b     (s1.e),
    .sum   (s_sum),
    .carry (s_carry)
  );

  assign s_prod = s_sum[PROD_W-1:0];
  assign s_ovf  = s1.a[SUM_W] | s_carry | s_sum[PROD_W];
`else
  assign s_prod = s1.a[PROD_W-1:0];
  assign s_ovf  = |s1.a[SUM_W:PROD_W];
`endif

  // Stage 1: capture A and E on every accepted input; empty when passed on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_fresh <= 1'b0;
      s1       <= '0;
    end else begin
      s1_fresh <= accept;
      if (accept) begin
        s1_valid <= 1'b1;
        s1.a     <= {a_carry, a_sum};
        s1.e     <= e_sum;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: output register, held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      product   <= '0;
      ovf       <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      product   <= s_prod;
      ovf       <= s_ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Error counter: one count per freshly accepted input with a nonzero E.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (s1_fresh && (s1.e != '0) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_layer4_final_add.sv
// Testbench for layer4_final_add: scoreboard of expected products, checked
// with immediate assertions. Honours LAYER4_ERROR_RECOVERY_EN when defined.
module tb_layer4_final_add;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready, in_ready_s;
  logic [22:0] d1, d2;
  logic [15:0] em, en;
  logic        out_valid, out_valid_s;
  logic        out_ready;
  logic [31:0] product, product_s;
  logic        ovf, ovf_s;
  logic [15:0] err_cnt;
  logic [1:0]  err_cnt_s;

  typedef struct {
    logic [31:0] prod;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_err = 0;
  bit   pend = 1'b0;
  int   delivered = 0;

  always #5 clk = ~clk;

  layer4_final_add dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .d1(d1), .d2(d2), .em(em), .en(en), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .ovf(ovf), .err_cnt(err_cnt)
  );

  layer4_final_add #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .d1(d1), .d2(d2), .em(em), .en(en), .out_valid(out_valid_s),
    .out_ready(out_ready), .product(product_s), .ovf(ovf_s), .err_cnt(err_cnt_s)
  );

  function automatic exp_t model(input logic [22:0] a1, input logic [22:0] a2,
                                 input logic [15:0] m, input logic [15:0] n);
    exp_t        r;
    logic [33:0] s;
    s = 34'(a1) * 34'd2 + 34'(a2) * 34'd512;
`ifdef LAYER4_ERROR_RECOVERY_EN
    s = s + 34'(m) * 34'd32 + 34'(n) * 34'd8192;
`else
    if (m != n) s = s + 34'd0;
`endif
    r.prod = s[31:0];
    r.ovf  = |s[33:32];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [22:0] a1, input logic [22:0] a2,
                               input logic [15:0] m, input logic [15:0] n);
    in_valid = v;
    d1 = a1;
    d2 = a2;
    em = m;
    en = n;
  endtask

  // One clock cycle: entered just after a negedge with inputs driven,
  // returns at the next negedge.
  task automatic tick(output bit acc);
    int sat;
    #1;
    sat = (exp_err > 3) ? 3 : exp_err;
    checkOutput("err_cnt", 64'(err_cnt), 64'(exp_err));
    checkOutput("err_cnt_sat", 64'(err_cnt_s), 64'(sat));
    if (out_valid) begin
      checkOutput("out_valid_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        checkOutput("product", 64'(product), 64'(sb[0].prod));
        checkOutput("ovf", 64'(ovf), 64'(sb[0].ovf));
        if (out_ready) begin
          void'(sb.pop_front());
          delivered++;
        end
      end
    end
    if (pend && exp_err < 65535) exp_err++;
    acc  = in_valid && in_ready;
    pend = acc && ((em | en) != 16'd0);
    if (acc) sb.push_back(model(d1, d2, em, en));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit          acc;
    int          idx;
    int          start;
    logic [22:0] r1, r2;
    logic [15:0] rm, rn;
    logic [22:0] bp_d1 [5];
    logic [15:0] bp_em [5];
    logic [31:0] exp_basic;

`ifdef LAYER4_ERROR_RECOVERY_EN
    exp_basic = 32'h0000_2222;
`else
    exp_basic = 32'h0000_0202;
`endif
    bp_d1 = '{23'h000011, 23'h000022, 23'h000033, 23'h000044, 23'h0};
    bp_em = '{16'h0001, 16'h0000, 16'h0003, 16'h0004, 16'h0};

    $display("[TB] reset");
    rst_n = 1'b0;
    out_ready = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    #2;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_product", 64'(product), 64'd0);
    checkOutput("reset_ovf", 64'(ovf), 64'd0);
    checkOutput("reset_err_cnt", 64'(err_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready_after_reset", 64'(in_ready), 64'd1);

    $display("[TB] basic sum and latency");
    out_ready = 1'b1;
    applyStimulus(1, 23'd1, 23'd1, 16'd1, 16'd1);
    tick(acc);
    checkOutput("basic_accept", 64'(acc), 64'd1);
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    checkOutput("basic_latency_n1", 64'(out_valid), 64'd0);
    tick(acc);
    #1;
    checkOutput("basic_latency_n2", 64'(out_valid), 64'd1);
    checkOutput("basic_product", 64'(product), 64'(exp_basic));
    checkOutput("basic_err_cnt", 64'(err_cnt), 64'd1);
    tick(acc);

    $display("[TB] wrap to overflow");
    applyStimulus(1, 23'h000100, 23'h7FFFFF, 16'd0, 16'd0);
    tick(acc);
    applyStimulus(0, 0, 0, 0, 0);
    tick(acc);
    #1;
    checkOutput("wrap_product", 64'(product), 64'd0);
    checkOutput("wrap_ovf", 64'(ovf), 64'd1);
    tick(acc);

    $display("[TB] random traffic with random backpressure");
    idx = 0;
    r1 = 23'($urandom); r2 = 23'($urandom); rm = 16'($urandom); rn = 16'($urandom);
    for (int i = 0; i < 40 && idx < 6; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      applyStimulus(1, r1, r2, rm, rn);
      tick(acc);
      if (acc) begin
        idx++;
        r1 = 23'($urandom); r2 = 23'($urandom); rm = 16'($urandom); rn = 16'($urandom);
      end
    end
    checkOutput("random_all_accepted", 64'(idx), 64'd6);
    applyStimulus(0, 0, 0, 0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick(acc);
    checkOutput("random_drained", 64'(sb.size()), 64'd0);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(idx < 4, bp_d1[idx], 23'(idx + 5), bp_em[idx], 16'd0);
      if (k == 2) begin
        #1;
        checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
      end
      tick(acc);
      if (acc) idx++;
    end
    checkOutput("bp_accepted_two", 64'(idx), 64'd2);
    out_ready = 1'b1;
    start = delivered;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(idx < 4, bp_d1[idx], 23'(idx + 5), bp_em[idx], 16'd0);
      tick(acc);
      if (acc) idx++;
    end
    checkOutput("bp_one_per_cycle", 64'(delivered - start), 64'd4);
    checkOutput("bp_all_accepted", 64'(idx), 64'd4);
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 5 && sb.size() != 0; i++) tick(acc);
    checkOutput("bp_drained", 64'(sb.size()), 64'd0);

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(1, 23'h000123, 23'h000456, 16'h0007, 16'h0008);
    tick(acc);
    applyStimulus(1, 23'h000321, 23'h000654, 16'h0009, 16'h0000);
    tick(acc);
    applyStimulus(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_err_cnt", 64'(err_cnt), 64'd0);
    checkOutput("midrst_err_cnt_sat", 64'(err_cnt_s), 64'd0);
    sb.delete();
    exp_err = 0;
    pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) tick(acc);
    applyStimulus(1, 23'h00ABCD, 23'h001234, 16'h0000, 16'h0000);
    tick(acc);
    applyStimulus(0, 0, 0, 0, 0);
    start = delivered;
    for (int i = 0; i < 3; i++) tick(acc);
    checkOutput("midrst_fresh_delivered", 64'(delivered - start), 64'd1);

    $display("[TB] error counter saturation");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 23'(i * 3 + 1), 23'(i + 2), 16'(i + 1), 16'(i * 2));
      tick(acc);
    end
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(acc);
    checkOutput("sat_stops_at_3", 64'(err_cnt_s), 64'd3);
    checkOutput("err_cnt_five", 64'(err_cnt), 64'd5);
    checkOutput("sat_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
